// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes and FSM states.
package lsu_pkg;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_e;
endpackage

// File: rtl/lsu_align.sv
// Little-endian lane handling: load extract/extend and store lane merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_word_o
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word_i[{lane_i, 3'b000} +: 8];
    half_v = lane_i[1] ? word_i[31:16] : word_i[15:0];
    ld_data_o = word_i;
    case (size_i)
      SIZE_B:  ld_data_o = {{24{sign_i & byte_v[7]}}, byte_v};
      SIZE_H:  ld_data_o = {{16{sign_i & half_v[15]}}, half_v};
      default: ld_data_o = word_i;
    endcase
  end

  // Store merge keeps the untouched lanes of the previously read word.
  always_comb begin
    st_word_o = word_i;
    case (size_i)
      SIZE_B: st_word_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      SIZE_H: begin
        if (lane_i[1]) st_word_o[31:16] = wdata_i[15:0];
        else           st_word_o[15:0]  = wdata_i[15:0];
      end
      default: st_word_o = wdata_i;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store unit in front of a word-only data memory.
// Define LSU_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 32
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        mem_WE,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  input  logic [31:0] mem_RD
);
  state_e      state_q, state_d;
  logic        we_q, sign_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, data_q;
  logic        rsp_valid_q, rsp_err_q;
  logic [31:0] rsp_rdata_q;

  logic        accept;
  logic        req_err, misal_err;
  logic [31:0] addr_al;
  logic [31:0] ld_data, st_word;

  assign accept = req_valid && (state_q == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misal_err = ((req_size == SIZE_H) && req_addr[0]) ||
                     ((req_size == SIZE_W) && (req_addr[1:0] != 2'b00));
  assign addr_al   = req_addr;
`else
  // Without trapping, the low bits are simply forced to natural alignment.
  assign misal_err = 1'b0;
  always_comb begin
    addr_al = req_addr;
    if (req_size == SIZE_H) addr_al[0]   = 1'b0;
    if (req_size == SIZE_W) addr_al[1:0] = 2'b00;
  end
`endif

  assign req_err = (req_size == SIZE_X) ||
                   (req_addr[31:2] >= 30'(MEM_WORDS)) ||
                   misal_err;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)                           state_d = RESP;
          else if (req_we && req_size == SIZE_W) state_d = WR;
          else                                   state_d = RD;
        end
      end
      RD:      state_d = we_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      size_q  <= SIZE_B;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_size;
        sign_q  <= req_sign;
        addr_q  <= addr_al;
        wdata_q <= req_wdata;
        err_q   <= req_err;
      end
      if (state_q == RD) data_q <= mem_RD;
    end
  end

  // Response is registered on the way out of RESP, giving a one-cycle pulse.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= (state_q == RESP);
      rsp_err_q   <= (state_q == RESP) && err_q;
      rsp_rdata_q <= ((state_q == RESP) && !we_q && !err_q) ? ld_data : 32'h0;
    end
  end

  lsu_align u_align (
    .word_i    (data_q),
    .lane_i    (addr_q[1:0]),
    .size_i    (size_q),
    .sign_i    (sign_q),
    .wdata_i   (wdata_q),
    .ld_data_o (ld_data),
    .st_word_o (st_word)
  );

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_WE    = (state_q == WR);
  assign mem_A     = {2'b00, addr_q[31:2]};
  assign mem_WD    = (state_q == WR) ? st_word : 32'h0;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural 32-word data memory.
module tb_load_store_unit;
  logic        CLK = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_sign;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err, mem_WE;
  logic [31:0] rsp_rdata, mem_A, mem_WD, mem_RD;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem     [32];
  logic [31:0] ref_mem [32];
  int          cyc = 0, we_cnt = 0, rsp_cnt = 0;
  int          checks = 0, errors = 0;

  load_store_unit #(.MEM_WORDS(32)) dut (
    .CLK(CLK), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_WE(mem_WE), .mem_A(mem_A), .mem_WD(mem_WD), .mem_RD(mem_RD)
  );

  always #5 CLK = ~CLK;

  assign mem_RD = (mem_A < 32) ? mem[mem_A[4:0]] : 32'h0;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (mem_WE) begin
      we_cnt <= we_cnt + 1;
      if (mem_A < 32) mem[mem_A[4:0]] <= mem_WD;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin : mon
    exp_t m;
    if (rst && rsp_valid) begin
      rsp_cnt++;
      if (sb.size() == 0) chk("unexp_rsp", 1, 0);
      else begin
        m = sb.pop_front();
        chk("rsp_err", rsp_err, m.err);
        chk("rsp_rdata", rsp_rdata, m.rdata);
        chk("rsp_lat", cyc - m.acc, m.lat);
      end
    end
  end

  function automatic void model(input logic we, input logic [1:0] sz, input logic sg,
                                input logic [31:0] ad, input logic [31:0] wd,
                                output logic err, output logic [31:0] rd, output int lat);
    logic [31:0] a, w;
    logic [7:0]  b;
    logic [15:0] h;
    a   = ad;
    err = (sz == 2'b11) || (a[31:2] >= 30'd32);
`ifdef LSU_MISALIGN_TRAP_EN
    err = err || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
`else
    if (sz == 2'b01) a[0] = 1'b0;
    if (sz == 2'b10) a[1:0] = 2'b00;
`endif
    rd  = 32'h0;
    lat = 1;
    if (!err) begin
      w = ref_mem[a[6:2]];
      if (!we) begin
        lat = 2;
        case (sz)
          2'b00: begin b = w[a[1:0]*8 +: 8]; rd = sg ? {{24{b[7]}}, b} : {24'h0, b}; end
          2'b01: begin h = a[1] ? w[31:16] : w[15:0]; rd = sg ? {{16{h[15]}}, h} : {16'h0, h}; end
          default: rd = w;
        endcase
      end else begin
        lat = (sz == 2'b10) ? 2 : 3;
        case (sz)
          2'b00: w[a[1:0]*8 +: 8] = wd[7:0];
          2'b01: if (a[1]) w[31:16] = wd[15:0]; else w[15:0] = wd[15:0];
          default: w = wd;
        endcase
        ref_mem[a[6:2]] = w;
      end
    end
  endfunction

  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd);
    exp_t e;
    int   t;
    t = 0;
    while (!(req_ready && sb.size() == 0) && t < 50) begin @(negedge CLK); t++; end
    if (t >= 50) chk("idle_timeout", 0, 1);
    model(we, sz, sg, ad, wd, e.err, e.rdata, e.lat);
    e.acc     = cyc + 1;
    req_valid = 1'b1; req_we = we; req_size = sz; req_sign = sg;
    req_addr  = ad;   req_wdata = wd;
    sb.push_back(e);
    @(posedge CLK);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 20) begin @(negedge CLK); t++; end
    if (t >= 20) begin chk("rsp_timeout", sb.size(), 0); sb.delete(); end
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0;
    for (int i = 0; i < 32; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_sign = 1'b0; req_addr = '0; req_wdata = '0;
    #12;
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_mem_we", mem_WE, 0);
    chk("rst_mem_a", mem_A, 0);
    chk("rst_mem_wd", mem_WD, 0);
    @(negedge CLK); rst = 1'b1; @(negedge CLK);

    issue(1, 2'b10, 0, 32'h08, 32'h11223344); wait_done();
    chk("sw_word2", mem[2], 32'h11223344);
    issue(0, 2'b10, 0, 32'h08, 0); wait_done();

    w0 = we_cnt;
    issue(1, 2'b00, 0, 32'h09, 32'h000000AB); wait_done();
    chk("sb_we_cycles", we_cnt - w0, 1);
    chk("sb_word2", mem[2], 32'h1122AB44);

    issue(0, 2'b00, 1, 32'h09, 0); wait_done();
    issue(0, 2'b00, 0, 32'h09, 0); wait_done();
    issue(0, 2'b01, 1, 32'h0A, 0); wait_done();
    issue(1, 2'b01, 0, 32'h0A, 32'h00008001); wait_done();
    chk("sh_word2", mem[2], 32'h8001AB44);

    issue(1, 2'b10, 0, 32'h04, 32'hCAFEF00D); wait_done();
    w0 = we_cnt;
    issue(0, 2'b10, 0, 32'h06, 0); wait_done();
    chk("lw6_no_write", we_cnt - w0, 0);

    w0 = we_cnt;
    issue(0, 2'b10, 0, 32'h80, 0); wait_done();
    issue(1, 2'b11, 0, 32'h00, 32'hDEADBEEF); wait_done();
    chk("err_no_write", we_cnt - w0, 0);

    // request pulsed while busy must be dropped
    r0 = rsp_cnt;
    issue(1, 2'b00, 0, 32'h10, 32'h0000005C);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h08;
    @(negedge CLK); @(negedge CLK);
    req_valid = 1'b0;
    wait_done();
    repeat (4) @(negedge CLK);
    chk("busy_one_rsp", rsp_cnt - r0, 1);

    // reset during the write cycle of an SB
    r0 = rsp_cnt; w0 = we_cnt;
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_sign = 1'b0;
    req_addr = 32'h08; req_wdata = 32'h00000077;
    @(posedge CLK); #1 req_valid = 1'b0;
    @(posedge CLK); @(negedge CLK);
    chk("rmw_in_wr", mem_WE, 1);
    rst = 1'b0;
    #1 chk("rst_we_async", mem_WE, 0);
    @(negedge CLK); rst = 1'b1;
    repeat (4) @(negedge CLK);
    chk("rst_no_rsp", rsp_cnt - r0, 0);
    chk("rst_no_write", we_cnt - w0, 0);
    chk("rst_word2", mem[2], ref_mem[2]);
    chk("rst_ready", req_ready, 1);
    issue(1, 2'b10, 0, 32'h0C, 32'h5A5A5A5A); wait_done();
    issue(0, 2'b10, 0, 32'h0C, 0); wait_done();

    for (int i = 0; i < 24; i++) begin
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 'h9F)), $urandom);
      wait_done();
    end
    for (int i = 0; i < 32; i++) chk($sformatf("mem%0d", i), mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
